// File: rtl/vedic_pkg.sv
// Shared types and helpers for sequencers built around vedic engines.
// Provides the FSM state encoding, nibble width and nibble-count helper.
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB = 4;

  function automatic int num_nib(input int w);
    return w / NIB;
  endfunction

endpackage

// File: rtl/vedic_mult_seq_ctrl_engine.sv
// 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier, purely combinational.
// Ports: a_i, b_i 4-bit operands; prod_o 8-bit product.
module vedicmult_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] prod_o
);

  function automatic logic [3:0] vm2(
    input logic [1:0] x,
    input logic [1:0] y
  );
    logic       c;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  logic [3:0] q0, q1, q2, q3;
  logic [5:0] hi;

  always_comb begin
    q0 = vm2(a_i[1:0], b_i[1:0]);
    q1 = vm2(a_i[3:2], b_i[1:0]);
    q2 = vm2(a_i[1:0], b_i[3:2]);
    q3 = vm2(a_i[3:2], b_i[3:2]);
    // Cross terms plus carry-out of the low pair, plus high pair at weight 4.
    hi = {2'b00, q1} + {2'b00, q2}
       + {4'b0000, q0[3:2]} + {q3, 2'b00};
    prod_o = {hi, q0[1:0]};
  end

endmodule

// File: rtl/vedic_mult_seq_ctrl.sv
// Sequential WxW multiplier: one 4x4 vedic engine walks all nibble pairs.
// Ports: in_valid/in_ready/in_a/in_b operand side; out_valid/out_ready/out_product result; busy.
module vedic_mult_seq_ctrl
  import vedic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_product,
  output logic           busy
);

  localparam int N  = num_nib(W);
  localparam int K  = N * N;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * W;

  if ((W % NIB) != 0 || W < 8) begin : g_bad_w
    $error("vedic_mult_seq_ctrl: W must be a multiple of 4 and >= 8");
  end

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [KW-1:0]   k_q, k_d;

  logic [KW-1:0]   i_idx, j_idx;
  logic [3:0]      a_nib, b_nib;
  logic [7:0]      prod8;
  logic [PW-1:0]   term;
  int              sh;

  // i runs fastest, j steps once per row of N nibbles.
  assign i_idx = KW'(k_q % KW'(N));
  assign j_idx = KW'(k_q / KW'(N));
  assign a_nib = a_q[NIB*i_idx +: NIB];
  assign b_nib = b_q[NIB*j_idx +: NIB];

  vedicmult_4bit u_engine (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .prod_o (prod8)
  );

  always_comb begin
    sh   = NIB * (int'(i_idx) + int'(j_idx));
    term = PW'(prod8) << sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + term;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(K - 1)) begin
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_product = acc_q;

endmodule

// File: tb/tb_vedic_mult_seq_ctrl.sv
// Scoreboard bench for vedic_mult_seq_ctrl at W=8 (directed) and W=16 (random).
// Expected products come from plain multiplication of the issued operands.
module tb_vedic_mult_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst8, v8, rdy8, ov8, ordy8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        rst16, v16, rdy16, ov16, ordy16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  vedic_mult_seq_ctrl #(.W(8)) u8 (
    .clk(clk), .rst(rst8),
    .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(ordy8),
    .out_product(p8), .busy(busy8)
  );

  vedic_mult_seq_ctrl #(.W(16)) u16 (
    .clk(clk), .rst(rst16),
    .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16),
    .out_valid(ov16), .out_ready(ordy16),
    .out_product(p16), .busy(busy16)
  );

  logic [15:0] q8[$];
  logic [31:0] qe16[$];
  int          qc16[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst8 && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        chk("p8_unexpected", 1, 0);
      end else begin
        chk("p8", p8, q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst16 && ov16 && ordy16) begin
      if (qe16.size() == 0) begin
        chk("p16_unexpected", 1, 0);
      end else begin
        chk("p16", p16, qe16.pop_front());
        chk("lat16", cyc - qc16.pop_front(), 16);
      end
    end
  end

  task automatic go8(input logic [7:0] a,
                     input logic [7:0] b,
                     input bit push);
    chk("rdy8_before", rdy8, 1);
    a8 = a;
    b8 = b;
    v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    if (push) q8.push_back(16'(a) * 16'(b));
    chk("busy8_calc", busy8, 1);
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov8 && n < 50);
  endtask

  task automatic test8;
    int  n;
    bit  seen;
    // reset state
    rst8 = 1'b1; v8 = 0; ordy8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", rdy8, 1);
    chk("rst_ov", ov8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_p", p8, 0);
    rst8 = 1'b0;
    @(posedge clk); #1;

    // FF*FF, consumer always ready
    ordy8 = 1'b1;
    go8(8'hFF, 8'hFF, 1);
    wait8(n);
    chk("lat_ff", n, 4);
    chk("rdy_in_done", rdy8, 0);
    @(posedge clk); #1;
    chk("pulse_ff", ov8, 0);
    chk("rdy_after_ff", rdy8, 1);

    // zero operand still takes K cycles
    go8(8'h00, 8'hA5, 1);
    wait8(n);
    chk("lat_zero", n, 4);
    chk("rdy_in_done0", rdy8, 0);
    @(posedge clk); #1;
    chk("rdy_after_zero", rdy8, 1);

    // stalled consumer, new operands ignored
    ordy8 = 1'b0;
    go8(8'h3C, 8'h5A, 1);
    wait8(n);
    chk("lat_stall", n, 4);
    v8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_v", ov8, 1);
      chk("hold_p", p8, 16'h1518);
    end
    chk("rdy_stall", rdy8, 0);
    v8 = 1'b0;
    ordy8 = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_v", ov8, 0);
    chk("stall_release_busy", busy8, 0);

    // reset in the middle of CALC
    go8(8'h77, 8'h99, 0);
    @(posedge clk); #1;
    rst8 = 1'b1;
    #1;
    chk("midrst_ov", ov8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_p", p8, 0);
    chk("midrst_rdy", rdy8, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov8) seen = 1;
    end
    chk("midrst_no_valid", seen, 0);
    go8(8'h12, 8'h34, 1);
    wait8(n);
    chk("lat_post_rst", n, 4);
    @(posedge clk); #1;
  endtask

  task automatic test16;
    int          last;
    int          acc;
    int          w;
    logic [15:0] a, b;
    rst16 = 1'b1; v16 = 0; ordy16 = 1; a16 = 0; b16 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0;
    last = -1000;
    for (int t = 0; t < 200; t++) begin
      w = 0;
      @(negedge clk);
      while (!rdy16 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) begin
        chk("rdy16_timeout", 1, 0);
        break;
      end
      if (t == 0) begin
        a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      a16 = a; b16 = b; v16 = 1'b1;
      acc = cyc + 1;
      qe16.push_back(32'(a) * 32'(b));
      qc16.push_back(acc);
      if (t > 0) chk("gap16", (acc - last) >= 17, 1);
      last = acc;
      @(negedge clk);
    end
    v16 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    v8 = 0; v16 = 0; ordy8 = 0; ordy16 = 1;
    a8 = 0; b8 = 0; a16 = 0; b16 = 0;
    fork
      test8();
      test16();
    join
    for (int i = 0; i < 100; i++) begin
      if (q8.size() == 0 && qe16.size() == 0) break;
      @(posedge clk);
    end
    chk("drain8", q8.size(), 0);
    chk("drain16", qe16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
